mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single memory / L2 interface between the instruction cache (port 0) and the data cache (port 1).
- Accepts one word read or write per grant and forwards it to memory.
- Holds the grant until memory signals ready, then returns read data and an acknowledge to the winning requester.
- Sits between the L1 caches and the memory / L2 controller.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory/L2 port between the I-cache (port 0) and D-cache (port 1).
// One word access per grant; the grant is held until memory signals ready, then the winner is acked.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [ADDR_WIDTH-1:0] i_p0_addr,
    input  logic                  i_p0_re,
    input  logic                  i_p0_we,
    input  logic [DATA_WIDTH-1:0] i_p0_wdata,
    output logic [DATA_WIDTH-1:0] o_p0_rdata,
    output logic                  o_p0_ack,
    input  logic [ADDR_WIDTH-1:0] i_p1_addr,
    input  logic                  i_p1_re,
    input  logic                  i_p1_we,
    input  logic [DATA_WIDTH-1:0] i_p1_wdata,
    output logic [DATA_WIDTH-1:0] o_p1_rdata,
    output logic                  o_p1_ack,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_ready,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_rr;       // 1 = port 1 favoured on the next tie
    logic                  r_gnt;
    logic                  r_mem_re;
    logic                  r_mem_we;
    logic                  r_p0_ack;
    logic                  r_p1_ack;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_p0_rdata;
    logic [DATA_WIDTH-1:0] r_p1_rdata;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_pick;
    logic                  w_pick_we;
    logic [ADDR_WIDTH-1:0] w_pick_addr;
    logic [DATA_WIDTH-1:0] w_pick_wdata;

    assign w_req0 = i_p0_re | i_p0_we;
    assign w_req1 = i_p1_re | i_p1_we;

    always_comb begin
        w_pick = w_req1;
        if (w_req0 && w_req1)
            w_pick = (FIXED_PRIO != 0) ? 1'b1 : r_rr;
    end

    // re and we together is treated as a write
    assign w_pick_we    = w_pick ? i_p1_we    : i_p0_we;
    assign w_pick_addr  = w_pick ? i_p1_addr  : i_p0_addr;
    assign w_pick_wdata = w_pick ? i_p1_wdata : i_p0_wdata;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_rr       <= 1'b0;
            r_gnt      <= 1'b0;
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_p0_ack   <= 1'b0;
            r_p1_ack   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else begin
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req0 || w_req1) begin
                        // pointer flips on every grant, contested or not
                        r_rr     <= ~r_rr;
                        r_gnt    <= w_pick;
                        r_addr   <= w_pick_addr;
                        r_wdata  <= w_pick_wdata;
                        r_mem_we <= w_pick_we;
                        r_mem_re <= ~w_pick_we;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (i_mem_ready) begin
                        if (!r_mem_we) begin
                            if (r_gnt) r_p1_rdata <= i_mem_rdata;
                            else       r_p0_rdata <= i_mem_rdata;
                        end
                        r_mem_re <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_p0_ack <= ~r_gnt;
                        r_p1_ack <= r_gnt;
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_re    = r_mem_re;
    assign o_mem_we    = r_mem_we;
    assign o_p0_ack    = r_p0_ack;
    assign o_p1_ack    = r_p1_ack;
    assign o_p0_rdata  = r_p0_rdata;
    assign o_p1_rdata  = r_p1_rdata;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, fixed-priority sequence, and randomized traffic
// against a transaction-level reference model, on a round-robin and a fixed-priority instance.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] A0 = 32'h40, A1 = 32'h10;
    localparam logic [31:0] W0 = 32'h0BADF00D, W1 = 32'h12345678;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic [AW-1:0] p0_addr, p1_addr;
    logic          p0_re, p0_we, p1_re, p1_we;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] p0_rdata [2];
    logic [DW-1:0] p1_rdata [2];
    logic [DW-1:0] mem_wdata[2];
    logic [AW-1:0] mem_addr [2];
    logic          p0_ack[2], p1_ack[2], mem_re[2], mem_we[2], busy[2];

    int checks = 0;
    int errors = 0;

    always #5 i_clock = ~i_clock;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) u_rr (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_p0_addr(p0_addr), .i_p0_re(p0_re), .i_p0_we(p0_we), .i_p0_wdata(p0_wdata),
        .o_p0_rdata(p0_rdata[0]), .o_p0_ack(p0_ack[0]),
        .i_p1_addr(p1_addr), .i_p1_re(p1_re), .i_p1_we(p1_we), .i_p1_wdata(p1_wdata),
        .o_p1_rdata(p1_rdata[0]), .o_p1_ack(p1_ack[0]),
        .o_mem_addr(mem_addr[0]), .o_mem_re(mem_re[0]), .o_mem_we(mem_we[0]),
        .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready),
        .o_busy(busy[0]));

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) u_fp (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_p0_addr(p0_addr), .i_p0_re(p0_re), .i_p0_we(p0_we), .i_p0_wdata(p0_wdata),
        .o_p0_rdata(p0_rdata[1]), .o_p0_ack(p0_ack[1]),
        .i_p1_addr(p1_addr), .i_p1_re(p1_re), .i_p1_we(p1_we), .i_p1_wdata(p1_wdata),
        .o_p1_rdata(p1_rdata[1]), .o_p1_ack(p1_ack[1]),
        .o_mem_addr(mem_addr[1]), .o_mem_re(mem_re[1]), .o_mem_we(mem_we[1]),
        .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready),
        .o_busy(busy[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clock);
        #1;
    endtask

    // code: bit0 = re, bit1 = we; fixed addr/wdata per port for the directed tests
    task automatic drive(input int p, input logic [1:0] code);
        if (p == 0) begin
            p0_re = code[0]; p0_we = code[1]; p0_addr = A0; p0_wdata = W0;
        end else begin
            p1_re = code[0]; p1_we = code[1]; p1_addr = A1; p1_wdata = W1;
        end
    endtask

    task automatic do_reset;
        i_reset = 1'b1;
        drive(0, 2'b00);
        drive(1, 2'b00);
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick;
        tick;
        i_reset = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  r0, r1;
        logic        rdy;
        logic [31:0] rdata;
        logic [1:0]  eop;       // 0 none, 1 mem read strobe, 2 mem write strobe
        logic        eport;
        logic        ea0, ea1;
        logic [31:0] erd0, erd1;
        logic        ebusy;
    } vec_t;

    function automatic vec_t V(input int rst, input int r0, input int r1, input int rdy,
                               input int rdata, input int eop, input int eport,
                               input int ea0, input int ea1, input int erd0, input int erd1,
                               input int ebusy);
        vec_t v;
        v.rst = (rst != 0); v.r0 = 2'(r0); v.r1 = 2'(r1); v.rdy = (rdy != 0);
        v.rdata = rdata; v.eop = 2'(eop); v.eport = (eport != 0);
        v.ea0 = (ea0 != 0); v.ea1 = (ea1 != 0); v.erd0 = erd0; v.erd1 = erd1;
        v.ebusy = (ebusy != 0);
        return v;
    endfunction

    task automatic run_table;
        vec_t tbl[$];
        int D, E, R12, R15, R18, R21, C2;
        D = 32'hDEADBEEF; E = 32'hEEEEEEEE; R12 = 32'h11111111; R15 = 32'h22222222;
        R18 = 32'h33333333; R21 = 32'h44444444; C2 = 32'hCAFE0002;
        // single read on port 0, ready on the 3rd BUSY cycle
        tbl.push_back(V(0,1,0,0,0,        1,0, 0,0, 0,0, 1));
        tbl.push_back(V(0,1,0,0,0,        1,0, 0,0, 0,0, 1));
        tbl.push_back(V(0,1,0,0,0,        1,0, 0,0, 0,0, 1));
        tbl.push_back(V(0,1,0,1,D,        0,0, 1,0, D,0, 1));
        tbl.push_back(V(0,1,0,0,0,        0,0, 0,0, D,0, 0));
        tbl.push_back(V(0,0,0,1,32'h5555, 0,0, 0,0, D,0, 0));
        // single write on port 1, zero-wait
        tbl.push_back(V(0,0,2,0,0,        2,1, 0,0, D,0, 1));
        tbl.push_back(V(0,0,2,1,32'h7777, 0,0, 0,1, D,0, 1));
        tbl.push_back(V(0,0,2,0,0,        0,0, 0,0, D,0, 0));
        tbl.push_back(V(0,0,0,0,0,        0,0, 0,0, D,0, 0));
        // reset, then both ports requesting continuously: p0,p1,p0,p1
        tbl.push_back(V(1,0,0,0,0,        0,0, 0,0, 0,0, 0));
        tbl.push_back(V(0,1,1,1,E,        1,0, 0,0, 0,0, 1));
        tbl.push_back(V(0,1,1,1,R12,      0,0, 1,0, R12,0, 1));
        tbl.push_back(V(0,1,1,1,E,        0,0, 0,0, R12,0, 0));
        tbl.push_back(V(0,1,1,1,E,        1,1, 0,0, R12,0, 1));
        tbl.push_back(V(0,1,1,1,R15,      0,0, 0,1, R12,R15, 1));
        tbl.push_back(V(0,1,1,1,E,        0,0, 0,0, R12,R15, 0));
        tbl.push_back(V(0,1,1,1,E,        1,0, 0,0, R12,R15, 1));
        tbl.push_back(V(0,1,1,1,R18,      0,0, 1,0, R18,R15, 1));
        tbl.push_back(V(0,1,1,1,E,        0,0, 0,0, R18,R15, 0));
        tbl.push_back(V(0,1,1,1,E,        1,1, 0,0, R18,R15, 1));
        tbl.push_back(V(0,1,1,1,R21,      0,0, 0,1, R18,R21, 1));
        tbl.push_back(V(0,0,0,0,0,        0,0, 0,0, R18,R21, 0));
        // port 1 arrives while port 0 write is BUSY
        tbl.push_back(V(0,2,0,0,0,        2,0, 0,0, R18,R21, 1));
        tbl.push_back(V(0,2,1,0,0,        2,0, 0,0, R18,R21, 1));
        tbl.push_back(V(0,2,1,1,32'hCAFE0001, 0,0, 1,0, R18,R21, 1));
        tbl.push_back(V(0,2,1,0,0,        0,0, 0,0, R18,R21, 0));
        tbl.push_back(V(0,0,1,0,0,        1,1, 0,0, R18,R21, 1));
        tbl.push_back(V(0,0,1,1,C2,       0,0, 0,1, R18,C2, 1));
        tbl.push_back(V(0,0,1,0,0,        0,0, 0,0, R18,C2, 0));
        tbl.push_back(V(0,0,0,0,0,        0,0, 0,0, R18,C2, 0));
        // reset during BUSY abandons the access; re+we counts as write afterwards
        tbl.push_back(V(0,1,0,0,0,        1,0, 0,0, R18,C2, 1));
        tbl.push_back(V(1,1,0,1,32'h9999, 0,0, 0,0, 0,0, 0));
        tbl.push_back(V(0,0,0,0,0,        0,0, 0,0, 0,0, 0));
        tbl.push_back(V(0,0,3,0,0,        2,1, 0,0, 0,0, 1));
        tbl.push_back(V(0,0,3,1,32'h8888, 0,0, 0,1, 0,0, 1));
        tbl.push_back(V(0,0,3,0,0,        0,0, 0,0, 0,0, 0));
        tbl.push_back(V(0,0,0,0,0,        0,0, 0,0, 0,0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            i_reset = tbl[i].rst;
            drive(0, tbl[i].r0);
            drive(1, tbl[i].r1);
            mem_ready = tbl[i].rdy;
            mem_rdata = tbl[i].rdata;
            tick;
            chk($sformatf("row%0d mem_re", i), mem_re[0], tbl[i].eop == 2'd1);
            chk($sformatf("row%0d mem_we", i), mem_we[0], tbl[i].eop == 2'd2);
            if (tbl[i].eop != 2'd0)
                chk($sformatf("row%0d mem_addr", i), mem_addr[0], tbl[i].eport ? A1 : A0);
            if (tbl[i].eop == 2'd2)
                chk($sformatf("row%0d mem_wdata", i), mem_wdata[0], tbl[i].eport ? W1 : W0);
            if (tbl[i].rst) begin
                chk($sformatf("row%0d rst addr", i), mem_addr[0], 32'h0);
                chk($sformatf("row%0d rst wdata", i), mem_wdata[0], 32'h0);
            end
            chk($sformatf("row%0d ack0", i), p0_ack[0], tbl[i].ea0);
            chk($sformatf("row%0d ack1", i), p1_ack[0], tbl[i].ea1);
            chk($sformatf("row%0d rdata0", i), p0_rdata[0], tbl[i].erd0);
            chk($sformatf("row%0d rdata1", i), p1_rdata[0], tbl[i].erd1);
            chk($sformatf("row%0d busy", i), busy[0], tbl[i].ebusy);
        end
        i_reset = 1'b0;
    endtask

    task automatic run_fixed;
        do_reset;
        drive(0, 2'b01); drive(1, 2'b01);
        mem_ready = 1'b1; mem_rdata = 32'hF1;
        tick;
        chk("fp first grant addr", mem_addr[1], A1);
        chk("fp first grant re", mem_re[1], 1'b1);
        chk("rr first grant addr", mem_addr[0], A0);
        tick;
        chk("fp ack1 #1", p1_ack[1], 1'b1);
        chk("fp rdata1 #1", p1_rdata[1], 32'hF1);
        chk("fp no ack0 #1", p0_ack[1], 1'b0);
        tick;
        chk("fp idle busy", busy[1], 1'b0);
        mem_rdata = 32'hF2;
        tick;
        chk("fp second grant addr", mem_addr[1], A1);
        tick;
        chk("fp ack1 #2", p1_ack[1], 1'b1);
        chk("fp no ack0 #2", p0_ack[1], 1'b0);
        chk("fp rdata1 #2", p1_rdata[1], 32'hF2);
        tick;
        drive(1, 2'b00);
        mem_rdata = 32'hF3;
        tick;
        chk("fp p0 grant addr", mem_addr[1], A0);
        chk("fp p0 grant re", mem_re[1], 1'b1);
        tick;
        chk("fp ack0", p0_ack[1], 1'b1);
        chk("fp rdata0", p0_rdata[1], 32'hF3);
        chk("fp no ack1", p1_ack[1], 1'b0);
        drive(0, 2'b00);
        tick;
    endtask

    // Randomized traffic; the model tracks owner and phase of the single in-flight access.
    task automatic run_random(input int d, input int fp, input int ncyc);
        int ph, own, ptr, w;
        logic mwe;
        logic [31:0] maddr, mwd;
        logic [31:0] mrd[2];
        bit act[2], drop[2], gap[2];
        logic [1:0] acode[2];
        logic [31:0] aaddr[2], awd[2];
        int waitc[2], issued[2], acked[2];
        bit preq[2], pwe[2], prdy;
        logic [31:0] paddr[2], pwd[2], prdata;
        logic ack[2];
        ph = 0; own = 0; ptr = 0; mwe = 0; maddr = 0; mwd = 0;
        for (int p = 0; p < 2; p++) begin
            mrd[p] = 0; act[p] = 0; drop[p] = 0; gap[p] = 0; acode[p] = 0;
            aaddr[p] = 0; awd[p] = 0; waitc[p] = 0; issued[p] = 0; acked[p] = 0;
        end
        do_reset;
        for (int c = 0; c < ncyc + 200; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (gap[p]) gap[p] = 0;
                else if (!act[p] && c < ncyc && $urandom_range(0, 3) == 0) begin
                    act[p] = 1; acode[p] = 2'($urandom_range(1, 3));
                    aaddr[p] = $urandom; awd[p] = $urandom; issued[p]++; waitc[p] = 0;
                end
            end
            p0_addr = aaddr[0]; p0_wdata = awd[0];
            p0_re = act[0] & acode[0][0]; p0_we = act[0] & acode[0][1];
            p1_addr = aaddr[1]; p1_wdata = awd[1];
            p1_re = act[1] & acode[1][0]; p1_we = act[1] & acode[1][1];
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            for (int p = 0; p < 2; p++) begin
                preq[p] = act[p]; pwe[p] = acode[p][1]; paddr[p] = aaddr[p]; pwd[p] = awd[p];
            end
            prdy = mem_ready; prdata = mem_rdata;
            tick;
            if (ph == 2) ph = 0;
            else if (ph == 0) begin
                if (preq[0] || preq[1]) begin
                    w = (preq[0] && preq[1]) ? ((fp != 0) ? 1 : ptr) : (preq[1] ? 1 : 0);
                    ptr ^= 1;
                    own = w; mwe = pwe[w]; maddr = paddr[w]; mwd = pwd[w];
                    ph = 1;
                end
            end else if (prdy) begin
                if (!mwe) mrd[own] = prdata;
                ph = 2;
            end
            chk($sformatf("rnd%0d c%0d busy", d, c), busy[d], ph != 0);
            chk($sformatf("rnd%0d c%0d mem_re", d, c), mem_re[d], ph == 1 && !mwe);
            chk($sformatf("rnd%0d c%0d mem_we", d, c), mem_we[d], ph == 1 && mwe);
            if (ph == 1) chk($sformatf("rnd%0d c%0d mem_addr", d, c), mem_addr[d], maddr);
            if (ph == 1 && mwe) chk($sformatf("rnd%0d c%0d mem_wdata", d, c), mem_wdata[d], mwd);
            chk($sformatf("rnd%0d c%0d ack0", d, c), p0_ack[d], ph == 2 && own == 0);
            chk($sformatf("rnd%0d c%0d ack1", d, c), p1_ack[d], ph == 2 && own == 1);
            chk($sformatf("rnd%0d c%0d rdata0", d, c), p0_rdata[d], mrd[0]);
            chk($sformatf("rnd%0d c%0d rdata1", d, c), p1_rdata[d], mrd[1]);
            ack[0] = p0_ack[d]; ack[1] = p1_ack[d];
            for (int p = 0; p < 2; p++) begin
                if (drop[p]) begin
                    act[p] = 0; drop[p] = 0; gap[p] = 1;
                end else if (act[p] && ack[p] === 1'b1) begin
                    drop[p] = 1; acked[p]++;
                end else if (act[p]) begin
                    waitc[p]++;
                    if (waitc[p] > 60) begin
                        chk($sformatf("rnd%0d p%0d wait bound", d, p), waitc[p], 60);
                        waitc[p] = 0;
                    end
                end
            end
        end
        chk($sformatf("rnd%0d p0 completions", d), acked[0], issued[0]);
        chk($sformatf("rnd%0d p1 completions", d), acked[1], issued[1]);
    endtask

    initial begin
        do_reset;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset%0d busy", d), busy[d], 1'b0);
            chk($sformatf("reset%0d mem_re", d), mem_re[d], 1'b0);
            chk($sformatf("reset%0d mem_we", d), mem_we[d], 1'b0);
            chk($sformatf("reset%0d mem_addr", d), mem_addr[d], 32'h0);
            chk($sformatf("reset%0d mem_wdata", d), mem_wdata[d], 32'h0);
            chk($sformatf("reset%0d ack0", d), p0_ack[d], 1'b0);
            chk($sformatf("reset%0d ack1", d), p1_ack[d], 1'b0);
            chk($sformatf("reset%0d rdata0", d), p0_rdata[d], 32'h0);
            chk($sformatf("reset%0d rdata1", d), p1_rdata[d], 32'h0);
        end
        run_table;
        run_fixed;
        run_random(0, 0, 1500);
        run_random(1, 1, 1500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
